// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// FSM/op encodings and small decode helpers.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_kind_t;

  // Any of the eight HI/LO-class functs (0100xx or 0110xx).
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f[5:4] == 2'b01) && !f[2];
  endfunction

  // MULT/MULTU/DIV/DIVU (0110xx).
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative magnitude datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per asserted 'step'. Operands are unsigned
// magnitudes; sign handling lives in the parent.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               load,
  input  logic               step,
  input  op_kind_t           kind,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  // acc: running high half (mul) or partial remainder (div).
  // shreg: multiplier shifting out (mul) or dividend out / quotient in (div).
  logic [WIDTH-1:0] acc, shreg, opb;
  op_kind_t         kind_q;
  logic [WIDTH:0]   add_sum, shifted;
  logic [WIDTH-1:0] sub_res;
  logic             sub_ok;

  // Next-step arithmetic for both op kinds.
  always_comb begin
    add_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : '0);
    shifted = {acc, shreg[WIDTH-1]};
    sub_ok  = shifted >= {1'b0, opb};
    // When sub_ok the true difference is below opb, so the low bits suffice.
    sub_res = shifted[WIDTH-1:0] - opb;
  end

  // Operand load, then one iteration per step.
  always_ff @(posedge clk) begin
    if (load) begin
      acc    <= '0;
      shreg  <= a_mag;
      opb    <= b_mag;
      kind_q <= kind;
    end else if (step) begin
      if (kind_q == OP_DIV) begin
        acc   <= sub_ok ? sub_res : shifted[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], sub_ok};
      end else begin
        acc   <= add_sum[WIDTH:1];
        shreg <= {add_sum[0], shreg[WIDTH-1:1]};
      end
    end
  end

  assign product   = {acc, shreg};
  assign quotient  = shreg;
  assign remainder = acc;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the execute stage: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO
// writes, MFHI/MFLO reads and the busy stall toward hazard control.
// Optional HILO_FAST_MULT_EN: multiplies use a single-cycle multiplier
// (IDLE->DONE->IDLE); divides stay iterative.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hilo,
  output logic             busy,
  output logic             stall
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi, lo;
  op_kind_t         op_q;
  logic             neg_p, neg_r, dbz_q;

  logic             accept, take_md, signed_op, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] core_prod, prod_abs, prod_s;
  logic [WIDTH-1:0] core_quot, core_rem;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  // Request decode, operand magnitudes, read port and stall.
  always_comb begin
    busy      = (state != IDLE);
    stall     = start && busy && is_hilo_funct(funct);
    accept    = start && !busy;
    take_md   = accept && is_muldiv_funct(funct);
    signed_op = !funct[0];
    neg_a     = signed_op && src_a[WIDTH-1];
    neg_b     = signed_op && src_b[WIDTH-1];
    mag_a     = neg_a ? -src_a : src_a;
    mag_b     = neg_b ? -src_b : src_b;
    hilo      = '0;
    if (accept && funct == FUNCT_MFHI) hilo = hi;
    if (accept && funct == FUNCT_MFLO) hilo = lo;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .load      (take_md),
    .step      (state == RUN),
    .kind      (funct[1] ? OP_DIV : OP_MUL),
    .a_mag     (mag_a),
    .b_mag     (mag_b),
    .product   (core_prod),
    .quotient  (core_quot),
    .remainder (core_rem)
  );

`ifdef HILO_FAST_MULT_EN
  // Single-cycle magnitude product, consumed in DONE.
  always_ff @(posedge clk) begin
    if (take_md && !funct[1]) fast_prod <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  end
  assign prod_abs = fast_prod;
`else
  assign prod_abs = core_prod;
`endif

  // Sign-correct the magnitude result; divide-by-zero forces LO to all ones
  // while HI naturally comes back as the original dividend.
  always_comb begin
    prod_s = neg_p ? -prod_abs : prod_abs;
    if (op_q == OP_MUL) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else begin
      res_hi = neg_r ? -core_rem : core_rem;
      res_lo = dbz_q ? '1 : (neg_p ? -core_quot : core_quot);
    end
  end

  // Control FSM plus HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= OP_MUL;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_md) begin
            op_q  <= funct[1] ? OP_DIV : OP_MUL;
            neg_p <= neg_a ^ neg_b;
            neg_r <= neg_a;
            dbz_q <= funct[1] && (src_b == '0);
            count <= '0;
`ifdef HILO_FAST_MULT_EN
            state <= funct[1] ? RUN : DONE;
`else
            state <= RUN;
`endif
          end else if (accept && funct == FUNCT_MTHI) begin
            hi <= src_a;
          end else if (accept && funct == FUNCT_MTLO) begin
            lo <= src_a;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == CNT_W'(ITER - 1)) state <= DONE;
        end
        DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: a cycle-level behavioural model of
// HI/LO and busy time, compared against the DUT every cycle, plus literal
// expectations taken from hand arithmetic.
module tb_hilo_muldiv_unit;

  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001;
  localparam logic [5:0] MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
  localparam logic [5:0] DIV  = 6'b011010, DIVU  = 6'b011011;
`ifdef HILO_FAST_MULT_EN
  localparam int BUSY_MUL = 1;
`else
  localparam int BUSY_MUL = 33;
`endif
  localparam int BUSY_DIV = 33;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0]  funct = 6'b0;
  logic [31:0] src_a = 32'b0, src_b = 32'b0;
  logic [31:0] hilo;
  logic        busy, stall;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  // model state
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          m_rem = 0;

  hilo_muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .src_a(src_a), .src_b(src_b), .hilo(hilo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit known(input logic [5:0] f);
    return f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
  endfunction

  // MIPS HI/LO results from plain arithmetic.
  function automatic void model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    p  = 64'b0;
    h  = 32'b0;
    l  = 32'b0;
    case (f)
      MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      DIV: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 0; end
        else begin l = ia / ib; h = ia % ib; end
      end
      default: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Model update at each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start) begin
      case (funct)
        MTHI: m_hi = src_a;
        MTLO: m_lo = src_a;
        MULT, MULTU: begin model_op(funct, src_a, src_b, p_hi, p_lo); m_rem = BUSY_MUL; end
        DIV, DIVU:   begin model_op(funct, src_a, src_b, p_hi, p_lo); m_rem = BUSY_DIV; end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic        e_busy, e_stall;
    logic [31:0] e_hilo;
    if (chk_en) begin
      e_busy  = (m_rem > 0);
      e_stall = start && e_busy && known(funct);
      e_hilo  = 0;
      if (start && !e_busy && funct == MFHI) e_hilo = m_hi;
      if (start && !e_busy && funct == MFLO) e_hilo = m_lo;
      check("model busy", 64'(busy), 64'(e_busy));
      check("model stall", 64'(stall), 64'(e_stall));
      check("model hilo", 64'(hilo), 64'(e_hilo));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [5:0] f, input logic [31:0] lit, input string name);
    start = 1; funct = f;
    @(negedge clk);
    check(name, 64'(hilo), 64'(lit));
    cycle();
    start = 0;
  endtask

  // Issue one op for a single cycle, then count busy cycles (bounded).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input string name);
    int n;
    start = 1; funct = f; src_a = a; src_b = b;
    cycle();
    start = 0;
    n = 0;
    while (busy && n < 200) begin n++; cycle(); end
    check(name, 64'(n), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] h, l;
    // pin the model itself on hand-computed values
    model_op(MULT, -32'sd3, 32'd7, h, l);
    check("model mult -3*7", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);
    model_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    check("model div min/-1", {h, l}, 64'h0000_0000_8000_0000);
    model_op(DIV, 32'd7, -32'sd2, h, l);
    check("model div 7/-2", {h, l}, 64'h0000_0001_FFFF_FFFD);

    reset = 1;
    cycle(); cycle();
    reset = 0;
    chk_en = 1;
    read_chk(MFHI, 32'h0, "reset hi");
    read_chk(MFLO, 32'h0, "reset lo");
    @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset stall", 64'(stall), 64'(0));
    cycle();

    start = 1; funct = MTHI; src_a = 32'h1234_5678; cycle(); start = 0;
    read_chk(MFHI, 32'h1234_5678, "mthi readback");
    read_chk(MFLO, 32'h0, "lo untouched");
    start = 1; funct = MTLO; src_a = 32'hCAFE_0001; cycle(); start = 0;
    read_chk(MFLO, 32'hCAFE_0001, "mtlo readback");

    run_op(MULT, -32'sd3, 32'd7, BUSY_MUL, "mult busy len");
    read_chk(MFLO, 32'hFFFF_FFEB, "mult -3*7 lo");
    read_chk(MFHI, 32'hFFFF_FFFF, "mult -3*7 hi");

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, BUSY_MUL, "multu busy len");
    read_chk(MFHI, 32'hFFFF_FFFE, "multu max hi");
    read_chk(MFLO, 32'h0000_0001, "multu max lo");

    run_op(MULT, 32'h8000_0000, 32'h8000_0000, BUSY_MUL, "mult min busy");
    read_chk(MFHI, 32'h4000_0000, "mult min*min hi");

    run_op(DIV, -32'sd7, 32'd2, BUSY_DIV, "div busy len");
    read_chk(MFLO, 32'hFFFF_FFFD, "div -7/2 lo");
    read_chk(MFHI, 32'hFFFF_FFFF, "div -7/2 hi");

    run_op(DIV, 32'd7, -32'sd2, BUSY_DIV, "div 7/-2 busy");
    read_chk(MFHI, 32'h0000_0001, "div 7/-2 hi");

    run_op(DIVU, 32'hFFFF_FFFF, 32'd2, BUSY_DIV, "divu busy len");
    read_chk(MFLO, 32'h7FFF_FFFF, "divu max/2 lo");
    read_chk(MFHI, 32'h0000_0001, "divu max/2 hi");

    run_op(DIVU, 32'd5, 32'd0, BUSY_DIV, "divu by 0 busy");
    read_chk(MFLO, 32'hFFFF_FFFF, "divu by 0 lo");
    read_chk(MFHI, 32'h0000_0005, "divu by 0 hi");

    run_op(DIV, -32'sd5, 32'd0, BUSY_DIV, "div by 0 busy");
    read_chk(MFLO, 32'hFFFF_FFFF, "div -5/0 lo");
    read_chk(MFHI, 32'hFFFF_FFFB, "div -5/0 hi");

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, BUSY_DIV, "div ovf busy");
    read_chk(MFLO, 32'h8000_0000, "div min/-1 lo");
    read_chk(MFHI, 32'h0000_0000, "div min/-1 hi");

    // MFLO presented 3 cycles into a DIV, with refused MTHI and junk funct first
    start = 1; funct = DIV; src_a = 32'd100; src_b = 32'd7; cycle();
    funct = MTHI; src_a = 32'hDEAD_BEEF; cycle();
    funct = 6'b100000; @(negedge clk);
    check("unknown funct no stall", 64'(stall), 64'(0));
    cycle();
    funct = MFLO;
    @(negedge clk);
    check("mflo stalled", 64'(stall), 64'(1));
    check("mflo hilo while busy", 64'(hilo), 64'(0));
    n = 0;
    while (busy && n < 200) begin n++; cycle(); end
    check("stall released", 64'(n < 200), 64'(1));
    @(negedge clk);
    check("mflo after div", 64'(hilo), 64'(14));
    cycle();
    start = 0;
    read_chk(MFHI, 32'd2, "div 100/7 hi");

    // MULTU held through its own DONE cycle: stalled there, re-accepted after
    start = 1; funct = MULTU; src_a = 32'd6; src_b = 32'd7;
    for (int i = 0; i < BUSY_MUL + 2; i++) cycle();
    start = 0;
    n = 0;
    while (busy && n < 200) begin n++; cycle(); end
    check("held mult drained", 64'(n < 200), 64'(1));
    read_chk(MFLO, 32'd42, "held multu lo");

    // reset in the middle of a divide
    run_op(MULTU, 32'd3, 32'd3, BUSY_MUL, "pre-reset mult");
    start = 1; funct = DIV; src_a = 32'd1000; src_b = 32'd3; cycle(); start = 0;
    for (int i = 0; i < 5; i++) cycle();
    reset = 1; cycle(); reset = 0;
    @(negedge clk);
    check("reset mid-div busy", 64'(busy), 64'(0));
    cycle();
    read_chk(MFHI, 32'h0, "reset mid-div hi");
    read_chk(MFLO, 32'h0, "reset mid-div lo");
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Sequential owner of the architectural HI/LO registers in the pipelined MIPS core; sits in the execute stage.
- Performs MULT/MULTU/DIV/DIVU iteratively over multiple cycles and services the MTHI/MTLO writes.
- Returns MFHI/MFLO read data and raises a stall toward hazard control while busy.
- Responder to the decode/execute issue interface (start + funct + operands).

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- ITER, WIDTH, iterations per MULT/DIV operation; must equal WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  execute stage holds a HI/LO-class instruction this cycle.
- funct  in  6  instruction function field.
- src_a  in  WIDTH  rs operand.
- src_b  in  WIDTH  rt operand.
- hilo  out  WIDTH  MFHI/MFLO read data.
- busy  out  1  multiply or divide in progress.
- stall  out  1  request refused this cycle; pipeline must hold and re-present it.

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, state=IDLE, count=0, busy=0, stall=0, hilo=0. Reset mid-operation aborts; HI/LO are not updated by the partial result.
- Funct codes:
  - 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other funct with start=1 is ignored: no stall, no state change, hilo=0.
- stall = start & busy, combinational, for any recognised funct. A refused request has no effect.
- hilo, combinational:
  - HI when start & funct==MFHI & !busy.
  - LO when start & funct==MFLO & !busy.
  - Otherwise 0.
- MTHI/MTLO (idle): HI or LO <= src_a at the next edge. An MFHI/MFLO in the following cycle returns the new value.
- States:
  - IDLE: accept a MULT/DIV-class request. Latch |operand| magnitudes, result sign flags, and op kind. Then go to RUN, count=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; count increments. When count==ITER-1, go to DONE.
  - DONE: sign-correct the result and write HI/LO at this edge; then go to IDLE.
- busy = (state != IDLE). Latency from start edge to HI/LO valid = ITER+1 cycles. An MFHI issued in the cycle after DONE sees the result.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = 64-bit product, signed or unsigned per funct.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Boundaries:
  - Divide by zero, signed or unsigned: LO=32'hFFFF_FFFF, HI=src_a; still takes the full latency.
  - Signed 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
  - A start of MULT/DIV in the DONE cycle is stalled, because busy is still 1.

Optional Feature:
- Macro: HILO_FAST_MULT_EN.
- Defined: MULT/MULTU compute the product with a single-cycle multiplier. They go IDLE->DONE->IDLE, with busy high for 1 cycle and latency 2. DIV/DIVU are unchanged.
- Undefined: all four ops are iterative as specified above.

Decomposition:
- Package muldiv_pkg:
  - funct localparams (FUNCT_MFHI … FUNCT_DIVU).
  - state enum typedef (IDLE, RUN, DONE).
  - op kind enum (OP_MUL, OP_DIV).
  - WIDTH-based helper constants.
- Sub-module muldiv_iter_core:
  - Performs the per-cycle shift-add/shift-subtract step on magnitudes.
  - Interface: load, step, kind, operands in; product/quotient/remainder out.
- hilo_muldiv_unit keeps the FSM, sign handling, HI/LO registers, and read/stall logic.

Test Plan:
- Reset held 2 cycles, then MFHI and MFLO -> hilo=0 both; busy=0; stall=0.
- MTHI src_a=32'h1234_5678; next cycle MFHI -> hilo=32'h1234_5678; LO unchanged (0).
- MULT src_a=-3, src_b=7 -> busy 33 cycles; then MFLO=32'hFFFF_FFEB and MFHI=32'hFFFF_FFFF. With HILO_FAST_MULT_EN, busy lasts 1 cycle.
- DIV src_a=-7, src_b=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU 32'hFFFF_FFFF/2 -> LO=32'h7FFF_FFFF, HI=1.
- DIVU by 0 with src_a=5 -> LO=32'hFFFF_FFFF, HI=5. Signed 32'h8000_0000/-1 -> LO=32'h8000_0000, HI=0.
- MFLO issued 3 cycles into a DIV -> stall=1 and hilo=0 until busy falls; reset asserted mid-DIV -> HI=LO=0, busy=0 the next cycle.
